apbm_swc_arb: RTL

//  Round-robin arbiter sharing the single-transaction request port of apbm_swc (wreq/rreq/buffer

---
 rtl/apbm_swc_arb.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/apbm_swc_arb.sv
// ---------------------------------------------------------------------------
// apbm_swc_arb
//
// Shares the single-transaction request port of apbm_swc among REQ_NUM
// requesters (core LSU, DMA, debug). One APB transfer is in flight at a
// time. Completion, read data and slave error go back to the requester that
// was granted. Completion is detected by snooping penable/pready/pslverr on
// the APB bus.
//
// Configuration macro:
//   APBM_ARB_FIXED_PRIO_EN - when defined, the lowest requester index wins
//                            and there is no round-robin pointer. When it is
//                            undefined (the default), arbitration is
//                            round-robin.
//
// Ports:
//   pclk, prst             clock, asynchronous active-high reset
//   req                    per-requester request level, held until gnt
//   req_write              per-requester direction (1=write, 0=read)
//   req_addr, req_wdata    flattened payloads, requester i at [i*W +: W]
//   gnt                    one-hot pulse, payload has been captured
//   done                   one-hot pulse, transfer complete
//   rsp_rdata, rsp_err     response, valid only while done is high
//   wreq, rreq             request pulses to apbm_swc
//   wbuffaddr, wbuffdata   write address/data to apbm_swc
//   rbuffaddr              read address to apbm_swc
//   rbuffwrite, rbuffdata  read data return from apbm_swc
//   penable, pready,
//   pslverr                APB bus snoop
// ---------------------------------------------------------------------------
module apbm_swc_arb #(
  parameter int REQ_NUM = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [REQ_NUM-1:0]    req,
  input  logic [REQ_NUM-1:0]    req_write,
  input  logic [REQ_NUM*AW-1:0] req_addr,
  input  logic [REQ_NUM*DW-1:0] req_wdata,
  output logic [REQ_NUM-1:0]    gnt,
  output logic [REQ_NUM-1:0]    done,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  wreq,
  output logic                  rreq,
  output logic [DW-1:0]         wbuffdata,
  output logic [AW-1:0]         wbuffaddr,
  output logic [AW-1:0]         rbuffaddr,
  input  logic                  rbuffwrite,
  input  logic [DW-1:0]         rbuffdata,
  input  logic                  penable,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   win_q;
  logic [PW-1:0]   win_c;
  logic            found_c;
  logic            dir_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            err_q;
  logic [AW-1:0]   addr_arr  [REQ_NUM];
  logic [DW-1:0]   wdata_arr [REQ_NUM];

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

`ifndef APBM_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr_q;
  logic [PW:0]   ptr_inc;
  logic [PW-1:0] ptr_nxt;

  // The pointer moves to the slot just after the winner, wrapping at REQ_NUM.
  always_comb begin
    ptr_inc = {1'b0, win_c} + {{PW{1'b0}}, 1'b1};
    ptr_nxt = ptr_inc[PW-1:0];
    if (ptr_inc >= (PW+1)'(REQ_NUM)) ptr_nxt = '0;
  end
`endif

  // Winner search. Round-robin starts at the pointer and wraps upward. Fixed
  // priority starts at index 0.
  always_comb begin
    logic [PW:0]   pos;
    logic [PW-1:0] idx;
    win_c   = '0;
    found_c = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
`ifdef APBM_ARB_FIXED_PRIO_EN
      pos = (PW+1)'(k);
`else
      pos = {1'b0, ptr_q} + (PW+1)'(k);
      if (pos >= (PW+1)'(REQ_NUM)) pos = pos - (PW+1)'(REQ_NUM);
`endif
      idx = pos[PW-1:0];
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        win_c   = idx;
      end
    end
  end

  // The payload is captured when the grant is decided, so the requester may
  // change it as soon as gnt is seen. The slave error is latched at the end
  // of the ACCESS phase because read data only arrives one cycle later.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state   <= S_IDLE;
      win_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifndef APBM_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && found_c) begin
        win_q   <= win_c;
        dir_q   <= req_write[win_c];
        addr_q  <= addr_arr[win_c];
        wdata_q <= wdata_arr[win_c];
`ifndef APBM_ARB_FIXED_PRIO_EN
        ptr_q   <= ptr_nxt;
`endif
      end
      if (state == S_WAIT && penable && pready) err_q <= pslverr;
    end
  end

  // Next state and outputs. wreq/rreq are raised only in ISSUE, so apbm_swc
  // is idle whenever it sees a request. The buffer address and data stay on
  // the bus until the FSM returns to IDLE.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    wreq      = 1'b0;
    rreq      = 1'b0;
    wbuffaddr = '0;
    wbuffdata = '0;
    rbuffaddr = '0;
    case (state)
      S_IDLE: begin
        if (found_c) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        gnt[win_q] = 1'b1;
        wreq       = dir_q;
        rreq       = !dir_q;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (penable && pready) begin
          if (dir_q) begin
            done[win_q] = 1'b1;
            rsp_err     = pslverr;
            state_nxt   = S_IDLE;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rbuffwrite) begin
          done[win_q] = 1'b1;
          rsp_rdata   = rbuffdata;
          rsp_err     = err_q;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE) begin
      if (dir_q) begin
        wbuffaddr = addr_q;
        wbuffdata = wdata_q;
      end else begin
        rbuffaddr = addr_q;
      end
    end
  end

endmodule
